// File: rtl/eng_sched_pkg.sv
// rtl/eng_sched_pkg.sv - FSM state type and default widths for the engine share scheduler
package eng_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_RW      = 16;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first requester above ptr, wrapping modulo N
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_oh,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Scan from the farthest candidate down so the nearest one above ptr wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_oh      = '0;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eng_share_sched.sv
// rtl/eng_share_sched.sv - shares one ld/start/done compute engine among N requesters, round-robin
module eng_share_sched
    import eng_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int RW      = DEF_RW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] opnd,
    output logic [N-1:0]    ack,
    output logic [RW-1:0]   result,
    output logic            timeout_err,
    output logic            busy,
    output logic            eng_ld,
    output logic [DW-1:0]   eng_opnd,
    output logic            eng_start,
    input  logic            eng_done,
    input  logic [RW-1:0]   eng_result
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [IW-1:0] gnt;
    logic [N-1:0]  gnt_oh;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    // timeout_err doubles as the abort flag: it is only ever set on the WAIT->RESP edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_oh      <= '0;
            ptr         <= IW'(N - 1);
            cnt         <= '0;
            result      <= '0;
            eng_opnd    <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            eng_ld      <= 1'b0;
            eng_start   <= 1'b0;
        end else begin
            eng_ld      <= 1'b0;
            eng_start   <= 1'b0;
            ack         <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick_idx;
                        gnt_oh   <= pick_oh;
                        eng_opnd <= opnd[pick_idx*DW +: DW];
                        eng_ld   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    eng_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        result <= eng_result;
                        ack    <= gnt_oh;
                        state  <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        result      <= '0;
                        ack         <= gnt_oh;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    ptr   <= gnt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eng_share_sched.sv
// tb/tb_eng_share_sched.sv - directed bench with a transaction-level scheduler model for eng_share_sched
module tb_eng_share_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] opnd = 32'h44332211;
    logic [N-1:0]    ack;
    logic [RW-1:0]   result;
    logic            timeout_err;
    logic            busy;
    logic            eng_ld;
    logic [DW-1:0]   eng_opnd;
    logic            eng_start;
    logic            eng_done = 1'b0;
    logic [RW-1:0]   eng_result = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    int            eng_delay = 0;
    int            eng_cd    = 0;
    int            spur_req  = 0;
    int            spur_done = 0;
    logic [RW-1:0] res_val   = '0;

    int            t_ld = -1, t_start = -1, t_ack = -1, t_req = 0;
    logic [N-1:0]  last_ack = '0;
    logic [RW-1:0] last_res = '0;
    logic          last_to  = 1'b0;
    logic [N-1:0]  order [5];

    int            m_ptr = N - 1, m_gnt = 0, m_age = 0;
    bit            m_act = 1'b0, m_resp = 1'b0, m_to = 1'b0, m_found = 1'b0;
    logic [RW-1:0] m_res = '0;
    logic [DW-1:0] m_opnd = '0;
    logic [N-1:0]  e_ack;

    eng_share_sched #(.N(N), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .opnd        (opnd),
        .ack         (ack),
        .result      (result),
        .timeout_err (timeout_err),
        .busy        (busy),
        .eng_ld      (eng_ld),
        .eng_opnd    (eng_opnd),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_result  (eng_result)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: m_age counts cycles since the grant; age 1 = operand load, 2 = start, >=3 = waiting.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ptr = N - 1; m_act = 0; m_resp = 0; m_to = 0; m_age = 0;
            m_res = '0; m_opnd = '0;
        end else if (!m_act) begin
            if (req != 0) begin
                m_found = 0;
                for (int k = 1; k <= N; k++)
                    if (!m_found && req[(m_ptr + k) % N]) begin
                        m_gnt = (m_ptr + k) % N;
                        m_found = 1;
                    end
                m_act = 1; m_age = 1;
                m_opnd = opnd[m_gnt*DW +: DW];
            end
        end else if (m_resp) begin
            m_resp = 0; m_act = 0; m_to = 0; m_age = 0;
            m_ptr = m_gnt;
        end else begin
            if (m_age >= 3) begin
                if (eng_done) begin
                    m_resp = 1; m_res = eng_result; m_to = 0;
                end else if (m_age - 3 == TO - 1) begin
                    m_resp = 1; m_res = '0; m_to = 1;
                end
            end
            m_age++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (eng_ld) t_ld = cyc;
        if (eng_start) t_start = cyc;
        if (cmp_en) begin
            e_ack = m_resp ? (N'(1) << m_gnt) : '0;
            chk("ack", ack, e_ack);
            chk("timeout_err", timeout_err, m_resp && m_to);
            chk("busy", busy, m_act);
            chk("eng_ld", eng_ld, m_act && m_age == 1);
            chk("eng_start", eng_start, m_act && m_age == 2);
            chk("eng_opnd", eng_opnd, m_opnd);
            if (e_ack != 0) chk("result", result, m_res);
        end
    end

    // Engine stub: done eng_delay cycles after start (0 = never), plus injectable spurious pulses.
    initial forever begin
        @(posedge clk);
        #2;
        eng_done = 1'b0;
        if (rst) begin
            eng_cd = 0;
        end else begin
            if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    eng_done   = 1'b1;
                    eng_result = res_val;
                end
            end
            if (eng_start && eng_delay > 0) eng_cd = eng_delay;
        end
        if (spur_req != spur_done) begin
            spur_done  = spur_req;
            eng_done   = 1'b1;
            eng_result = 16'hDEAD;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                got = 1; t_ack = cyc;
                last_ack = ack; last_res = result; last_to = timeout_err;
            end
        end
        if (!got) begin
            chk("ack_wait_expired", got, 1);
            last_ack = '0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tick(2);
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_eng_opnd", eng_opnd, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        tick(1);

        // single requester 2, engine done 3 cycles after start
        res_val = 16'h1234; eng_delay = 3;
        req = 4'b0100; t_req = cyc;
        wait_ack(20);
        chk("t1_ld_lat", t_ld - t_req, 1);
        chk("t1_start_lat", t_start - t_req, 2);
        chk("t1_done_to_ack", t_ack - t_start, 4);
        chk("t1_ack", last_ack, 4'b0100);
        chk("t1_result", last_res, 16'h1234);
        chk("t1_to", last_to, 0);
        chk("t1_opnd", eng_opnd, 8'h33);
        req = '0;

        // all requesting from reset: strict rotation 0,1,2,3,0
        do_reset();
        eng_delay = 1; res_val = 16'h0B0B;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(20);
            chk("t2_rr_order", last_ack, order[i]);
        end
        req = '0;

        // requester 1 served, then 0 and 1 pending -> 0 first; minimum latency
        tick(1);
        req = 4'b0010; t_req = cyc;
        wait_ack(20);
        chk("t3_ack1", last_ack, 4'b0010);
        chk("t3_min_lat", t_ack - t_req, 4);
        req = 4'b0011;
        wait_ack(20);
        chk("t3_ack0", last_ack, 4'b0001);
        req = 4'b0010;
        wait_ack(20);
        chk("t3_ack1b", last_ack, 4'b0010);
        req = '0;

        // engine never finishes -> timeout abort, then normal service
        tick(1);
        eng_delay = 0; req = 4'b1000;
        wait_ack(40);
        chk("t4_ack", last_ack, 4'b1000);
        chk("t4_to", last_to, 1);
        chk("t4_result", last_res, 0);
        chk("t4_to_lat", t_ack - t_start, TO + 1);
        req = '0;
        eng_delay = 2; res_val = 16'h7777;
        req = 4'b0100;
        wait_ack(20);
        chk("t4_next_ack", last_ack, 4'b0100);
        chk("t4_next_to", last_to, 0);
        chk("t4_next_res", last_res, 16'h7777);
        req = '0;

        // spurious done in IDLE and LOAD is ignored
        tick(1);
        spur_req++;
        tick(1);
        chk("t5_idle_busy", busy, 0);
        eng_delay = 2; res_val = 16'h5A5A;
        req = 4'b0010;
        tick(1);
        spur_req++;
        wait_ack(20);
        chk("t5_ack", last_ack, 4'b0010);
        chk("t5_res", last_res, 16'h5A5A);
        chk("t5_lat", t_ack - t_start, 3);
        req = '0;

        // done on the final wait cycle beats the timeout
        tick(1);
        eng_delay = TO; res_val = 16'hC0DE;
        req = 4'b0001;
        wait_ack(40);
        chk("t6_ack", last_ack, 4'b0001);
        chk("t6_to", last_to, 0);
        chk("t6_res", last_res, 16'hC0DE);
        chk("t6_lat", t_ack - t_start, TO + 1);
        req = '0;

        // reset while waiting aborts silently; requester 0 wins afterwards
        tick(1);
        eng_delay = 0; req = 4'b0100;
        tick(5);
        chk("t7_in_wait", busy, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_ack", ack, 0);
        chk("t7_rst_opnd", eng_opnd, 0);
        chk("t7_rst_result", result, 0);
        chk("t7_rst_start", eng_start, 0);
        req = '0;
        tick(2);
        rst = 1'b0;
        eng_delay = 1;
        req = 4'b0011;
        wait_ack(20);
        chk("t7_first_after_rst", last_ack, 4'b0001);
        req = '0;

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
